// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the downstream sequence detector.
// Accepts a word over valid/ready, shifts it out on x_out, then idles for an optional gap.
module bit_serializer #(
  parameter int DATA_W     = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic              x_out,
  output logic              x_valid,
  output logic              word_done,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] PEN_BIT  = CNT_W'(DATA_W - 2);
  localparam logic [3:0]       GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] sreg, sreg_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [3:0]        gcnt, gcnt_n;
  logic              x_out_n, x_valid_n, word_done_n;

  // The register always holds the not-yet-emitted bits aligned so the next one sits at the head.
  function automatic logic head(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  assign in_ready = (state == IDLE) && !flush;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      gcnt      <= '0;
      x_out     <= 1'b0;
      x_valid   <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      cnt       <= cnt_n;
      gcnt      <= gcnt_n;
      x_out     <= x_out_n;
      x_valid   <= x_valid_n;
      word_done <= word_done_n;
    end
  end

  // Outputs are computed one cycle ahead so x_out/x_valid/word_done leave straight from flops.
  always_comb begin
    state_n     = state;
    sreg_n      = sreg;
    cnt_n       = cnt;
    gcnt_n      = gcnt;
    x_out_n     = 1'b0;
    x_valid_n   = 1'b0;
    word_done_n = 1'b0;
    if (flush) begin
      state_n = IDLE;
      sreg_n  = '0;
      cnt_n   = '0;
      gcnt_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state_n   = SHIFT;
            sreg_n    = advance(in_data);
            cnt_n     = '0;
            x_out_n   = head(in_data);
            x_valid_n = 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == LAST_BIT) begin
            state_n = (GAP_CYCLES > 0) ? GAP : IDLE;
            cnt_n   = '0;
            gcnt_n  = '0;
          end else begin
            cnt_n       = cnt + CNT_W'(1);
            sreg_n      = advance(sreg);
            x_out_n     = head(sreg);
            x_valid_n   = 1'b1;
            word_done_n = (cnt == PEN_BIT);
          end
        end
        GAP: begin
          if (gcnt == GAP_LAST) begin
            state_n = IDLE;
            gcnt_n  = '0;
          end else begin
            gcnt_n = gcnt + 4'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: two instances (MSB-first/gap 1, LSB-first/gap 2) share stimulus
// and are checked every cycle against a frame-position model, plus literal directed checks.
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;

  logic rdy_a, x_a, xv_a, wd_a, busy_a;
  logic rdy_b, x_b, xv_b, wd_b, busy_b;

  always #5 clk = ~clk;

  bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b1), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a),
    .flush(flush), .x_out(x_a), .x_valid(xv_a), .word_done(wd_a), .busy(busy_a)
  );

  bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b0), .GAP_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_b),
    .flush(flush), .x_out(x_b), .x_valid(xv_b), .word_done(wd_b), .busy(busy_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each instance is at a position in its frame. 0 = idle, 1..W = data bit p,
  // W+1..W+gap = gap cycle. A frame lasts W+gap cycles, then one idle cycle to accept.
  int           gap_of[2] = '{1, 2};
  bit           msb_of[2] = '{1'b1, 1'b0};
  int           pos[2]    = '{0, 0};
  logic [W-1:0] word[2];

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst)                pos[i] = 0;
      else if (flush)          pos[i] = 0;
      else if (pos[i] != 0)    pos[i] = (pos[i] == W + gap_of[i]) ? 0 : pos[i] + 1;
      else if (in_valid) begin
        pos[i]  = 1;
        word[i] = in_data;
      end
    end
  end

  // {x_out, x_valid, word_done, busy, in_ready}
  function automatic logic [4:0] model_out(input int p, input logic [W-1:0] w, input bit msb);
    logic x;
    x = 1'b0;
    if (p >= 1 && p <= W) x = msb ? w[W-p] : w[p-1];
    return {x, (p >= 1 && p <= W), (p == W), (p != 0), (p == 0 && !flush)};
  endfunction

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    logic [4:0] e;
    #1;
    if (cmp_en) begin
      e = model_out(pos[0], word[0], msb_of[0]);
      chk("a.x_out", x_a, e[4]);    chk("a.x_valid", xv_a, e[3]);
      chk("a.word_done", wd_a, e[2]); chk("a.busy", busy_a, e[1]);
      chk("a.in_ready", rdy_a, e[0]);
      e = model_out(pos[1], word[1], msb_of[1]);
      chk("b.x_out", x_b, e[4]);    chk("b.x_valid", xv_b, e[3]);
      chk("b.word_done", wd_b, e[2]); chk("b.busy", busy_b, e[1]);
      chk("b.in_ready", rdy_b, e[0]);
    end
  end

  // Sends one word from idle and collects W bits from each instance, first bit at the MSB.
  task automatic send_collect(input logic [W-1:0] d, input logic [W-1:0] exp_a,
                              input logic [W-1:0] exp_b, input string tag);
    logic [W-1:0] sa, sb;
    logic         va, vb;
    int           da, db;
    va = 1'b1; vb = 1'b1; da = -1; db = -1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = ~d;
      #1;
      sa[W-1-i] = x_a;
      sb[W-1-i] = x_b;
      va &= xv_a;
      vb &= xv_b;
      if (wd_a) da = (da == -1) ? i : 99;
      if (wd_b) db = (db == -1) ? i : 99;
    end
    chk({tag, ".a.bits"}, sa, exp_a);
    chk({tag, ".b.bits"}, sb, exp_b);
    chk({tag, ".a.valid"}, va, 1);
    chk({tag, ".b.valid"}, vb, 1);
    chk({tag, ".a.done_at"}, da, W - 1);
    chk({tag, ".b.done_at"}, db, W - 1);
  endtask

  initial begin
    int   fa[2], fb[2];
    int   na, nb;
    logic pa, pb, seen;

    // Reset held low for three cycles
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset.x_out", x_a | x_b, 0);
    chk("reset.x_valid", xv_a | xv_b, 0);
    chk("reset.word_done", wd_a | wd_b, 0);
    chk("reset.busy", busy_a | busy_b, 0);
    chk("reset.in_ready", rdy_a & rdy_b, 1);

    // B6: MSB-first 10110110, LSB-first 01101101; then gap timing
    send_collect(8'hB6, 8'b10110110, 8'b01101101, "b6");
    @(negedge clk); #1;
    chk("b6.a.gap_x", {x_a, xv_a, busy_a, rdy_a}, 4'b0010);
    @(negedge clk); #1;
    chk("b6.a.ready_after_gap", rdy_a, 1);
    chk("b6.b.gap2_busy", {x_b, busy_b, rdy_b}, 3'b010);
    @(negedge clk); #1;
    chk("b6.b.ready_after_gap", rdy_b, 1);

    // 0F
    send_collect(8'h0F, 8'b00001111, 8'b11110000, "0f");
    repeat (4) @(negedge clk);

    // Back-to-back with in_valid held: FF then 81
    fa = '{0, 0}; fb = '{0, 0}; na = 0; nb = 0; pa = 1'b0; pb = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) in_data = 8'h81;
      #1;
      if (xv_a && !pa) begin if (na < 2) fa[na] = c; na++; end
      if (xv_b && !pb) begin if (nb < 2) fb[nb] = c; nb++; end
      pa = xv_a;
      pb = xv_b;
      if (c == 9 || c == 10) chk("b2b.b.gap_zero", {x_b, xv_b}, 2'b00);
      if (c == 12) in_valid = 1'b0;
    end
    chk("b2b.a.spacing", fa[1] - fa[0], W + 1 + 1);
    chk("b2b.b.spacing", fb[1] - fb[0], W + 2 + 1);
    repeat (14) @(negedge clk);

    // Flush after three bits of AA
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush.a", {x_a, xv_a, wd_a, busy_a, rdy_a}, 5'b00001);
    chk("flush.b", {x_b, xv_b, wd_b, busy_b, rdy_b}, 5'b00001);
    send_collect(8'h55, 8'b01010101, 8'b10101010, "55");
    repeat (4) @(negedge clk);

    // Reset mid-word after four bits of FF
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    chk("midrst.outs", {x_a, xv_a, wd_a, busy_a, x_b, xv_b, wd_b, busy_b}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      seen |= xv_a | xv_b | x_a | x_b;
    end
    chk("midrst.no_residual", seen, 0);
    send_collect(8'h3C, 8'b00111100, 8'b00111100, "3c");
    repeat (4) @(negedge clk);

    // Randomised traffic with occasional flush and reset pulses
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(9) < 6);
      in_data  = W'($urandom);
      flush    = ($urandom_range(39) == 0);
      rst      = ($urandom_range(299) != 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    rst      = 1'b1;
    repeat (20) @(negedge clk);
    cmp_en = 1'b0;
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
